// File: rtl/nios2_control_timer_driver.sv
// Hardware initiator for a 16-bit Avalon-MM interval timer: programs period/mode, starts/stops,
// services the timeout IRQ and reads counter snapshots, one bus transfer per state.
module nios2_control_timer_driver #(
    parameter int unsigned TICK_W    = 16,
    parameter bit          COUNT_SAT = 1'b1
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              cmd_start_i,
    input  logic [31:0]       cmd_period_i,
    input  logic              cmd_continuous_i,
    input  logic              cmd_stop_i,
    input  logic              cmd_snap_i,
    output logic              busy_o,
    output logic              running_o,
    output logic              tick_o,
    output logic [TICK_W-1:0] tick_count_o,
    output logic              snap_valid_o,
    output logic [31:0]       snap_value_o,
    output logic [2:0]        m_address_o,
    output logic              m_chipselect_o,
    output logic              m_write_n_o,
    output logic [15:0]       m_writedata_o,
    input  logic [15:0]       m_readdata_i,
    input  logic              irq_i
);

    typedef enum logic [3:0] {
        StIdle, StRun, StWStop, StWPerL, StWPerH, StWCtrl, StWHalt, StWClr,
        StWSnap, StRSl, StRSh, StSnapCap
    } state_e;

    state_e            state_q, state_d;
    logic              stop_p_q, stop_p_d, start_p_q, start_p_d, snap_p_q, snap_p_d;
    logic [31:0]       period_q;
    logic              cont_q, run_cont_q, snap_ret_q;
    logic [31:0]       snap_q;
    logic [TICK_W-1:0] tick_cnt_q, tick_cnt_d;
    logic              req_stop, req_start, req_snap;

    // A request is visible in the same cycle as its pulse so IDLE reacts with no extra cycle.
    assign req_stop  = stop_p_q | cmd_stop_i;
    assign req_start = start_p_q | cmd_start_i;
    assign req_snap  = snap_p_q | cmd_snap_i;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle, StRun: begin
                if (req_stop)                       state_d = StWHalt;
                else if (state_q == StRun && irq_i) state_d = StWClr;
                else if (req_start)                 state_d = StWStop;
                else if (req_snap)                  state_d = StWSnap;
            end
            StWStop:   state_d = StWPerL;
            StWPerL:   state_d = StWPerH;
            StWPerH:   state_d = StWCtrl;
            StWCtrl:   state_d = StRun;
            StWHalt:   state_d = StIdle;
            StWClr:    state_d = run_cont_q ? StRun : StIdle;
            StWSnap:   state_d = StRSl;
            StRSl:     state_d = StRSh;
            StRSh:     state_d = StSnapCap;
            StSnapCap: state_d = snap_ret_q ? StRun : StIdle;
            default:   state_d = StIdle;
        endcase
    end

    always_comb begin
        m_chipselect_o = 1'b0;
        m_write_n_o    = 1'b1;
        m_address_o    = 3'd0;
        m_writedata_o  = 16'h0000;
        case (state_q)
            StWStop, StWHalt: begin
                m_chipselect_o = 1'b1;
                m_write_n_o    = 1'b0;
                m_address_o    = 3'd1;
                m_writedata_o  = 16'h0008;
            end
            StWPerL: begin
                m_chipselect_o = 1'b1;
                m_write_n_o    = 1'b0;
                m_address_o    = 3'd2;
                m_writedata_o  = period_q[15:0];
            end
            StWPerH: begin
                m_chipselect_o = 1'b1;
                m_write_n_o    = 1'b0;
                m_address_o    = 3'd3;
                m_writedata_o  = period_q[31:16];
            end
            StWCtrl: begin
                m_chipselect_o = 1'b1;
                m_write_n_o    = 1'b0;
                m_address_o    = 3'd1;
                m_writedata_o  = {13'b0, 1'b1, cont_q, 1'b1};
            end
            StWClr: begin
                m_chipselect_o = 1'b1;
                m_write_n_o    = 1'b0;
            end
            StWSnap: begin
                m_chipselect_o = 1'b1;
                m_write_n_o    = 1'b0;
                m_address_o    = 3'd4;
            end
            StRSl: begin
                m_chipselect_o = 1'b1;
                m_address_o    = 3'd4;
            end
            StRSh: begin
                m_chipselect_o = 1'b1;
                m_address_o    = 3'd5;
            end
            default: ;
        endcase
    end

    always_comb begin
        stop_p_d  = req_stop & (state_d != StWHalt);
        // A stop arriving after a start cancels it; arriving together, both run (stop first).
        start_p_d = req_start & (state_d != StWStop) & ~(cmd_stop_i & ~cmd_start_i);
        snap_p_d  = req_snap & (state_d != StWSnap);

        tick_cnt_d = tick_cnt_q;
        if (state_q == StWStop) begin
            tick_cnt_d = '0;
        end else if (state_q == StWClr && !(COUNT_SAT && (&tick_cnt_q))) begin
            tick_cnt_d = tick_cnt_q + TICK_W'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            stop_p_q   <= 1'b0;
            start_p_q  <= 1'b0;
            snap_p_q   <= 1'b0;
            period_q   <= 32'h0;
            cont_q     <= 1'b0;
            run_cont_q <= 1'b0;
            snap_ret_q <= 1'b0;
            snap_q     <= 32'h0;
            tick_cnt_q <= '0;
        end else begin
            stop_p_q   <= stop_p_d;
            start_p_q  <= start_p_d;
            snap_p_q   <= snap_p_d;
            tick_cnt_q <= tick_cnt_d;
            if (cmd_start_i) begin
                period_q <= cmd_period_i;
                cont_q   <= cmd_continuous_i;
            end
            // Mode used for servicing is frozen when the timer is actually started.
            if (state_q == StWCtrl) run_cont_q <= cont_q;
            if (state_d == StWSnap) snap_ret_q <= (state_q == StRun);
            if (state_q == StRSh) snap_q[15:0] <= m_readdata_i;
            if (state_q == StSnapCap) snap_q[31:16] <= m_readdata_i;
        end
    end

    assign busy_o       = (state_q != StIdle) | stop_p_q | start_p_q | snap_p_q;
    assign running_o    = (state_q == StRun);
    assign tick_o       = (state_q == StWClr);
    assign tick_count_o = tick_cnt_q;
    assign snap_valid_o = (state_q == StSnapCap);
    assign snap_value_o = (state_q == StSnapCap) ? {m_readdata_i, snap_q[15:0]} : snap_q;

endmodule

// File: tb/tb_nios2_control_timer_driver.sv
// Bench for nios2_control_timer_driver: behavioural interval timer slave, bus/tick scoreboard,
// plus two narrow-counter instances for saturate/wrap behaviour.
module tb_nios2_control_timer_driver;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic        cmd_start = 1'b0, cmd_cont = 1'b0, cmd_stop = 1'b0, cmd_snap = 1'b0;
    logic [31:0] cmd_period = 32'h0;
    logic        busy, running, tick, snap_valid, m_cs, m_wn, irq;
    logic [15:0] tick_count, m_wd, m_rd;
    logic [31:0] snap_value;
    logic [2:0]  m_addr;

    nios2_control_timer_driver #(.TICK_W(16), .COUNT_SAT(1'b1)) dut (
        .clk_i(clk), .rst_ni(rst_n), .cmd_start_i(cmd_start), .cmd_period_i(cmd_period),
        .cmd_continuous_i(cmd_cont), .cmd_stop_i(cmd_stop), .cmd_snap_i(cmd_snap),
        .busy_o(busy), .running_o(running), .tick_o(tick), .tick_count_o(tick_count),
        .snap_valid_o(snap_valid), .snap_value_o(snap_value), .m_address_o(m_addr),
        .m_chipselect_o(m_cs), .m_write_n_o(m_wn), .m_writedata_o(m_wd),
        .m_readdata_i(m_rd), .irq_i(irq)
    );

    // Narrow-counter instances, IRQ driven directly by the bench.
    logic       s_start = 1'b0, s_irq = 1'b0;
    logic [1:0] a_cnt, b_cnt;
    logic       a_busy, a_run, a_tick, a_sv, a_cs, a_wn, b_busy, b_run, b_tick, b_sv, b_cs, b_wn;
    logic [31:0] a_snap, b_snap;
    logic [2:0]  a_addr, b_addr;
    logic [15:0] a_wd, b_wd;

    nios2_control_timer_driver #(.TICK_W(2), .COUNT_SAT(1'b1)) u_sat (
        .clk_i(clk), .rst_ni(rst_n), .cmd_start_i(s_start), .cmd_period_i(32'd3),
        .cmd_continuous_i(1'b1), .cmd_stop_i(1'b0), .cmd_snap_i(1'b0),
        .busy_o(a_busy), .running_o(a_run), .tick_o(a_tick), .tick_count_o(a_cnt),
        .snap_valid_o(a_sv), .snap_value_o(a_snap), .m_address_o(a_addr),
        .m_chipselect_o(a_cs), .m_write_n_o(a_wn), .m_writedata_o(a_wd),
        .m_readdata_i(16'h0), .irq_i(s_irq)
    );

    nios2_control_timer_driver #(.TICK_W(2), .COUNT_SAT(1'b0)) u_wrap (
        .clk_i(clk), .rst_ni(rst_n), .cmd_start_i(s_start), .cmd_period_i(32'd3),
        .cmd_continuous_i(1'b1), .cmd_stop_i(1'b0), .cmd_snap_i(1'b0),
        .busy_o(b_busy), .running_o(b_run), .tick_o(b_tick), .tick_count_o(b_cnt),
        .snap_valid_o(b_sv), .snap_value_o(b_snap), .m_address_o(b_addr),
        .m_chipselect_o(b_cs), .m_write_n_o(b_wn), .m_writedata_o(b_wd),
        .m_readdata_i(16'h0), .irq_i(s_irq)
    );

    // Interval timer slave: status@0 {run,to}, control@1 {stop,start,cont,ito}.
    logic [31:0] t_per, t_cnt, t_snap;
    logic        t_to, t_run, t_ito, t_cont;
    assign irq = t_to & t_ito;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            t_per <= 32'h0; t_cnt <= 32'h0; t_snap <= 32'h0; m_rd <= 16'h0;
            t_to <= 1'b0; t_run <= 1'b0; t_ito <= 1'b0; t_cont <= 1'b0;
        end else begin
            if (t_run) begin
                if (t_cnt == 32'h0) begin
                    t_to  <= 1'b1;
                    t_cnt <= t_per;
                    if (!t_cont) t_run <= 1'b0;
                end else begin
                    t_cnt <= t_cnt - 32'h1;
                end
            end
            if (m_cs && !m_wn) begin
                case (m_addr)
                    3'd0: t_to <= 1'b0;
                    3'd1: begin
                        t_ito  <= m_wd[0];
                        t_cont <= m_wd[1];
                        if (m_wd[3]) t_run <= 1'b0;
                        else if (m_wd[2]) begin t_run <= 1'b1; t_cnt <= t_per; end
                    end
                    3'd2: t_per[15:0]  <= m_wd;
                    3'd3: t_per[31:16] <= m_wd;
                    3'd4, 3'd5: t_snap <= t_cnt;
                    default: ;
                endcase
            end else if (m_cs) begin
                case (m_addr)
                    3'd0: m_rd <= {14'b0, t_run, t_to};
                    3'd1: m_rd <= {14'b0, t_cont, t_ito};
                    3'd2: m_rd <= t_per[15:0];
                    3'd3: m_rd <= t_per[31:16];
                    3'd4: m_rd <= t_snap[15:0];
                    3'd5: m_rd <= t_snap[31:16];
                    default: m_rd <= 16'h0;
                endcase
            end
        end
    end

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Scoreboards: expected bus transfers {addr, write_n, data} and tick_count values.
    logic [19:0] bus_q[$];
    logic [15:0] cnt_q[$];
    int          tick_times[$];
    int          cyc = 0;
    logic        tick_pend = 1'b0;

    always @(negedge clk) begin
        cyc++;
        if (!rst_n) begin
            tick_pend = 1'b0;
        end else begin
            if (m_cs) begin
                check("bus_expected", 32'(bus_q.size() != 0), 32'd1);
                if (bus_q.size() != 0) check("bus_xfer", 32'({m_addr, m_wn, m_wd}),
                                             32'(bus_q.pop_front()));
            end
            if (tick_pend) begin
                check("irq_low_after_clr", 32'(irq), 32'd0);
                if (cnt_q.size() != 0) check("tick_count", 32'(tick_count),
                                             32'(cnt_q.pop_front()));
            end
            tick_pend = tick;
            if (tick) begin
                check("tick_expected", 32'(cnt_q.size() != 0), 32'd1);
                tick_times.push_back(cyc);
            end
        end
    end

    task automatic push_start(input logic [31:0] per, input logic cont);
        bus_q.push_back({3'd1, 1'b0, 16'h0008});
        bus_q.push_back({3'd2, 1'b0, per[15:0]});
        bus_q.push_back({3'd3, 1'b0, per[31:16]});
        bus_q.push_back({3'd1, 1'b0, 13'b0, 1'b1, cont, 1'b1});
    endtask

    task automatic pulse_start(input logic [31:0] per, input logic cont);
        cmd_period = per;
        cmd_cont   = cont;
        cmd_start  = 1'b1;
        @(negedge clk);
        cmd_start  = 1'b0;
    endtask

    task automatic stop_and_idle();
        bus_q.push_back({3'd1, 1'b0, 16'h0008});
        cmd_stop = 1'b1;
        @(negedge clk);
        cmd_stop = 1'b0;
        repeat (3) @(negedge clk);
        check("stop_running", 32'(running), 32'd0);
        check("stop_busy", 32'(busy), 32'd0);
    endtask

    task automatic do_snap(output logic [31:0] val);
        int n;
        bus_q.push_back({3'd4, 1'b0, 16'h0000});
        bus_q.push_back({3'd4, 1'b1, 16'h0000});
        bus_q.push_back({3'd5, 1'b1, 16'h0000});
        cmd_snap = 1'b1;
        @(negedge clk);
        cmd_snap = 1'b0;
        n = 0;
        while (!snap_valid && n < 10) begin @(negedge clk); n++; end
        check("snap_valid_seen", 32'(snap_valid), 32'd1);
        val = snap_value;
    endtask

    logic [1:0]  sat_exp[4];
    logic [1:0]  wrap_exp[4];
    logic [31:0] s1, s2;
    int          n;

    initial begin
        sat_exp  = '{2'd1, 2'd2, 2'd3, 2'd3};
        wrap_exp = '{2'd1, 2'd2, 2'd3, 2'd0};
        repeat (2) @(negedge clk);
        check("rst_cs", 32'(m_cs), 32'd0);
        check("rst_write_n", 32'(m_wn), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_tick_count", 32'(tick_count), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Saturating vs wrapping counter, period 3 continuous.
        s_start = 1'b1;
        @(negedge clk);
        s_start = 1'b0;
        repeat (5) @(negedge clk);
        check("sat_running", 32'({a_run, b_run}), 32'h3);
        for (int i = 0; i < 4; i++) begin
            s_irq = 1'b1;
            n = 0;
            do begin @(negedge clk); n++; end while (!a_tick && n < 10);
            check("sat_tick", 32'({a_tick, b_tick}), 32'h3);
            s_irq = 1'b0;
            @(negedge clk);
            check("sat_count", 32'(a_cnt), 32'(sat_exp[i]));
            check("wrap_count", 32'(b_cnt), 32'(wrap_exp[i]));
        end

        // Continuous period 9: start latency, three serviced timeouts 10 clocks apart.
        push_start(32'h9, 1'b1);
        for (int i = 1; i <= 3; i++) begin
            bus_q.push_back({3'd0, 1'b0, 16'h0000});
            cnt_q.push_back(16'(i));
        end
        tick_times.delete();
        pulse_start(32'h9, 1'b1);
        repeat (3) @(negedge clk);
        check("latency_not_yet", 32'(running), 32'd0);
        @(negedge clk);
        check("latency_running", 32'(running), 32'd1);
        n = 0;
        while (tick_times.size() < 3 && n < 100) begin @(negedge clk); n++; end
        check("three_ticks", 32'(tick_times.size()), 32'd3);
        if (tick_times.size() >= 3) begin
            check("tick_interval1", 32'(tick_times[1] - tick_times[0]), 32'd10);
            check("tick_interval2", 32'(tick_times[2] - tick_times[1]), 32'd10);
        end
        stop_and_idle();

        // Two snapshots in RUN: bounded by period and decreasing.
        push_start(32'd256, 1'b1);
        pulse_start(32'd256, 1'b1);
        repeat (5) @(negedge clk);
        do_snap(s1);
        check("snap1_le_period", 32'(s1 <= 32'd256), 32'd1);
        repeat (2) @(negedge clk);
        check("snap_returns_run", 32'(running), 32'd1);
        do_snap(s2);
        check("snap_decreasing", 32'(s2 < s1), 32'd1);
        stop_and_idle();

        // IRQ and stop in the same cycle: stop wins, no tick, timeout stays pending in timer.
        push_start(32'd5, 1'b1);
        pulse_start(32'd5, 1'b1);
        repeat (4) @(negedge clk);
        n = 0;
        while (!irq && n < 20) begin @(negedge clk); n++; end
        check("irq_seen", 32'(irq), 32'd1);
        bus_q.push_back({3'd1, 1'b0, 16'h0008});
        cmd_stop = 1'b1;
        @(negedge clk);
        cmd_stop = 1'b0;
        check("halt_no_tick", 32'(tick), 32'd0);
        @(negedge clk);
        check("halt_idle", 32'({running, busy}), 32'd0);
        check("timer_to_pending", 32'(t_to), 32'd1);

        // Reset while in W_PERH abandons the sequence.
        bus_q.push_back({3'd1, 1'b0, 16'h0008});
        bus_q.push_back({3'd2, 1'b0, 16'h0020});
        bus_q.push_back({3'd3, 1'b0, 16'h0000});
        pulse_start(32'h20, 1'b1);
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_outputs", 32'({m_cs, m_wn, m_addr, busy, running, tick, snap_valid}),
              32'({1'b0, 1'b1, 3'd0, 4'd0}));
        check("mid_rst_wdata", 32'(m_wd), 32'd0);
        check("mid_rst_snap_value", snap_value, 32'd0);
        check("mid_rst_bus_done", 32'(bus_q.size()), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // One-shot 0x0001_0004: single tick 0x10005 timer counts after start.
        push_start(32'h0001_0004, 1'b0);
        bus_q.push_back({3'd0, 1'b0, 16'h0000});
        cnt_q.push_back(16'd1);
        pulse_start(32'h0001_0004, 1'b0);
        repeat (4) @(negedge clk);
        check("oneshot_running", 32'(running), 32'd1);
        n = 0;
        while (!tick && n < 70000) begin @(negedge clk); n++; end
        check("oneshot_tick_delay", 32'(n), 32'h10006);
        @(negedge clk);
        check("oneshot_idle", 32'(running), 32'd0);
        repeat (20) @(negedge clk);
        check("oneshot_no_irq", 32'({irq, busy, t_run}), 32'd0);
        check("queues_drained", 32'(bus_q.size() + cnt_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
